// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit covering the eight
// RISC-V M-extension operations. Operands are converted to magnitudes when a
// request is accepted. The core runs unsigned shift-add (multiply) or
// restoring (divide) steps, and the sign is applied once in FIXUP.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   Flush               synchronous abort, wins over accept and output handshake
//   InValid / InReady   request handshake; InReady = state is IDLE
//   Funct3, OpA, OpB    operation select and operands, captured at accept
//   OutValid / OutReady result handshake; OutValid = state is DONE
//   Result              result, held while OutValid is high
//   Busy                high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | one radix-2 step per edge while counter != 0
// FIXUP | counter exhausted; sign-corrected result is registered
// DONE  | Result presented until OutReady (or Flush)

module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Busy
);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [2:0]       op;
   logic             neg;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opnd;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result_q;

   logic             accept;
   logic             a_signed, b_signed;
   logic             a_sgn, b_sgn;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, div_ovf, special;
   logic [WIDTH-1:0] special_res;
   logic             neg_in;

   logic [WIDTH:0]   shifted, trial, sum;
   logic [WIDTH-1:0] step_hi, step_lo;

   logic [2*WIDTH-1:0] prod, prod_c;
   logic [WIDTH-1:0]   quo_c, rem_c, fix_res;

   assign InReady  = (state == IDLE);
   assign OutValid = (state == DONE);
   assign Busy     = (state != IDLE);
   assign Result   = result_q;

   assign accept = InValid && InReady && !Flush;

   // ---------------------------------------------------------------- accept
   always_comb begin
      a_signed = (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                 (Funct3 == F_DIV)  || (Funct3 == F_REM);
      b_signed = (Funct3 == F_MULH) || (Funct3 == F_DIV) || (Funct3 == F_REM);
      a_sgn    = a_signed && OpA[WIDTH-1];
      b_sgn    = b_signed && OpB[WIDTH-1];
      a_mag    = a_sgn ? -OpA : OpA;
      b_mag    = b_sgn ? -OpB : OpB;

      div_zero = Funct3[2] && (OpB == '0);
      div_ovf  = ((Funct3 == F_DIV) || (Funct3 == F_REM)) &&
                 (OpA == {1'b1, {(WIDTH-1){1'b0}}}) && (OpB == '1);
      special  = div_zero || div_ovf;

      // Funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
      if (div_zero)
         special_res = Funct3[1] ? OpA : '1;
      else
         special_res = Funct3[1] ? '0 : OpA;

      // Remainder follows the dividend; every other result follows a XOR b.
      if (Funct3[2] && Funct3[1])
         neg_in = a_sgn;
      else
         neg_in = a_sgn ^ b_sgn;
   end

   // ------------------------------------------------------------ radix-2 step
   // Multiply: {hi,lo} holds partial product with the multiplier in lo,
   //           shifted right each step; carry out of the add enters hi MSB.
   // Divide:   hi is the partial remainder, lo shifts the dividend out and
   //           the quotient bits in. hi < divisor, so shifted fits WIDTH+1
   //           bits and the MSB of trial is a clean borrow flag.
   always_comb begin
      shifted = {hi, lo[WIDTH-1]};
      trial   = shifted - {1'b0, opnd};
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      step_hi = hi;
      step_lo = lo;
      if (op[2]) begin
         if (!trial[WIDTH]) begin
            step_hi = trial[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shifted[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], lo[WIDTH-1:1]};
      end
   end

   // ------------------------------------------------------------ sign fixup
   always_comb begin
      prod   = {hi, lo};
      prod_c = neg ? -prod : prod;
      quo_c  = neg ? -lo : lo;
      rem_c  = neg ? -hi : hi;
      case (op)
         F_MUL:                     fix_res = prod_c[WIDTH-1:0];
         F_MULH, F_MULHSU, F_MULHU: fix_res = prod_c[2*WIDTH-1:WIDTH];
         F_DIV, F_DIVU:             fix_res = quo_c;
         default:                   fix_res = rem_c;
      endcase
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept) state_nx = special ? DONE : BUSY;
         BUSY:  if (cnt == '0) state_nx = FIXUP;
         FIXUP: state_nx = DONE;
         DONE:  if (OutReady) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (Flush)
         state_nx = IDLE;
   end

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op       <= '0;
         neg      <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else if (accept) begin
         op   <= Funct3;
         neg  <= neg_in;
         hi   <= '0;
         lo   <= Funct3[2] ? a_mag : b_mag;
         opnd <= Funct3[2] ? b_mag : a_mag;
         cnt  <= CNT_W'(WIDTH);
         if (special)
            result_q <= special_res;
      end else if (!Flush) begin
         if (state == BUSY && cnt != '0) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - CNT_W'(1);
         end else if (state == FIXUP) begin
            result_q <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32). Stimulus pushes expected results into
// a queue; a monitor pops and compares at every output handshake.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         Flush;
   logic         InValid;
   logic         InReady;
   logic [2:0]   Funct3;
   logic [W-1:0] OpA, OpB;
   logic         OutValid;
   logic         OutReady;
   logic [W-1:0] Result;
   logic         Busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   string        name_q[$];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .Flush    (Flush),
      .InValid  (InValid),
      .InReady  (InReady),
      .Funct3   (Funct3),
      .OpA      (OpA),
      .OpB      (OpB),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Result   (Result),
      .Busy     (Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted output must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && OutValid && OutReady) begin
         if (exp_q.size() == 0) begin
            chk("unexpected output", {32'h0, Result}, 64'hDEAD_BEEF_DEAD_BEEF);
         end else begin
            string nm;
            logic [W-1:0] e;
            nm = name_q.pop_front();
            e  = exp_q.pop_front();
            chk(nm, {32'h0, Result}, {32'h0, e});
         end
      end
   end

   // Called at posedge+#1 with the DUT idle. lat = edges after the accept
   // edge until OutValid is seen (0 = already DONE right after accept).
   task automatic issue(input string nm, input logic [2:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
      int n;
      Funct3  = f;
      OpA     = a;
      OpB     = b;
      InValid = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      InValid = 1'b0;
      OpA     = $urandom;
      OpB     = $urandom;
      Funct3  = 3'($urandom_range(0, 7));
      n = 0;
      while (!OutValid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, " latency"}, 64'(n), 64'(lat));
      if (OutReady) begin
         @(posedge clk);
         #1;
         chk({nm, " idle after"}, {63'h0, InReady}, 64'h1);
      end
   endtask

   task automatic watch_no_valid(input string nm, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (OutValid) seen++;
      end
      chk(nm, 64'(seen), 64'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      Flush    = 1'b0;
      InValid  = 1'b0;
      Funct3   = 3'b000;
      OpA      = '0;
      OpB      = '0;
      OutReady = 1'b1;
      #2;
      chk("reset InReady",  {63'h0, InReady},  64'h1);
      chk("reset OutValid", {63'h0, OutValid}, 64'h0);
      chk("reset Busy",     {63'h0, Busy},     64'h0);
      chk("reset Result",   {32'h0, Result},   64'h0);
      repeat (2) @(posedge clk);
      #1;
      // First accept on the first edge after release.
      reset_n = 1'b1;
      issue("MUL 7x-3",         3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      issue("MUL low",          3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, 34);
      issue("MULHU ff*ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      issue("MULH -1*-1",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      issue("MULHSU -1*ff",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      issue("DIV -7/2",         3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
      issue("REM -7/2",         3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
      issue("DIV 7/-2",         3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      issue("REM 7/-2",         3'b110, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 34);
      issue("REMU 100/7",       3'b111, 32'd100,      32'd7,        32'd2,         34);
      issue("DIVU 5/0",         3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
      issue("REM x/0",          3'b110, 32'h1234_5678, 32'd0,       32'h1234_5678, 0);
      issue("REM ovf",          3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      issue("DIV ovf",          3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

      // Backpressure: hold OutReady low for 10 cycles in DONE.
      OutReady = 1'b0;
      issue("bp MUL 6x7",       3'b000, 32'd6,        32'd7,        32'd42,        34);
      for (int i = 0; i < 10; i++) begin
         chk("bp OutValid", {63'h0, OutValid}, 64'h1);
         chk("bp Result",   {32'h0, Result},   64'd42);
         chk("bp InReady",  {63'h0, InReady},  64'h0);
         @(posedge clk);
         #1;
      end
      OutReady = 1'b1;
      @(posedge clk);
      #1;
      chk("bp idle after", {63'h0, InReady}, 64'h1);

      // Flush in BUSY with InValid high: back to IDLE, no accept, no output.
      Funct3  = 3'b000;
      OpA     = 32'd9;
      OpB     = 32'd9;
      InValid = 1'b1;
      @(posedge clk);
      #1;
      InValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("flush pre Busy", {63'h0, Busy}, 64'h1);
      Flush   = 1'b1;
      InValid = 1'b1;
      @(posedge clk);
      #1;
      Flush   = 1'b0;
      InValid = 1'b0;
      chk("flush InReady", {63'h0, InReady}, 64'h1);
      chk("flush Busy",    {63'h0, Busy},    64'h0);
      watch_no_valid("flush no OutValid", 40);

      issue("DIVU 100/7",       3'b101, 32'd100,      32'd7,        32'd14,        34);

      // Async reset in BUSY cycle 12.
      Funct3  = 3'b000;
      OpA     = 32'd3;
      OpB     = 32'd5;
      InValid = 1'b1;
      @(posedge clk);
      #1;
      InValid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst InReady",  {63'h0, InReady},  64'h1);
      chk("rst OutValid", {63'h0, OutValid}, 64'h0);
      chk("rst Busy",     {63'h0, Busy},     64'h0);
      chk("rst Result",   {32'h0, Result},   64'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      watch_no_valid("rst no OutValid", 40);

      issue("MUL after rst",    3'b000, 32'd11,       32'd13,       32'd143,       34);

      chk("queue empty", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
